// File: rtl/tinyodin_obi_pkg.sv
// Shared types and constants for the tinyODIN OBI responder: region decode,
// per-core address widths and the default OBI request/response structs.
package tinyodin_obi_pkg;

    localparam int REGION_MSB = 21;
    localparam int REGION_LSB = 20;

    localparam int SPK_AW_DEF  = 6;
    localparam int NEUR_AW_DEF = 8;
    localparam int SYN_AW_DEF  = 13;

    typedef enum logic [1:0] {
        TGT_SPK  = 2'd0,
        TGT_NEUR = 2'd1,
        TGT_SYN  = 2'd2,
        TGT_CTRL = 2'd3
    } tgt_e;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    // One-hot SRAM strobe {syn,neur,spk}; the control region owns no SRAM.
    function automatic logic [2:0] tgt_onehot(input tgt_e tgt);
        logic [2:0] oh;
        oh = 3'b000;
        case (tgt)
            TGT_SPK:  oh = 3'b001;
            TGT_NEUR: oh = 3'b010;
            TGT_SYN:  oh = 3'b100;
            default:  oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/tinyodin_obi_decode.sv
// Combinational region decode: bus address -> target, zero-extended word
// address and a stall flag when the charge core owns the target SRAM.
module tinyodin_obi_decode
    import tinyodin_obi_pkg::*;
#(
    parameter int SPK_AW  = SPK_AW_DEF,
    parameter int NEUR_AW = NEUR_AW_DEF,
    parameter int SYN_AW  = SYN_AW_DEF
) (
    input  logic [31:0]       addr,
    input  logic              core_busy,
    output tgt_e              tgt,
    output logic [SYN_AW-1:0] word_addr,
    output logic              stall
);

    // Bits above the region field and above each core's width simply alias.
    logic unused_addr;
    assign unused_addr = ^addr;

    // Region select, per-core offset extraction and busy arbitration.
    always_comb begin
        tgt       = tgt_e'(addr[REGION_MSB:REGION_LSB]);
        word_addr = '0;
        stall     = 1'b0;
        case (tgt)
            TGT_SPK: begin
                word_addr[SPK_AW-1:0] = addr[SPK_AW-1:0];
            end
            TGT_NEUR: begin
                word_addr[NEUR_AW-1:0] = addr[NEUR_AW-1:0];
                stall                  = core_busy;
            end
            TGT_SYN: begin
                word_addr = addr[SYN_AW-1:0];
                stall     = core_busy;
            end
            default: begin
                word_addr = '0;
            end
        endcase
    end

endmodule

// File: rtl/tinyodin_obi_responder.sv
// OBI responder front-end of tinyODIN. Grants host requests, converts them
// into SRAM strobes, owns the control register and returns one response per
// accepted request on the following cycle.
//
//  state   | meaning
//  IDLE    | no response owed this cycle
//  RESP    | rvalid high; response for the request accepted last cycle
module tinyodin_obi_responder
    import tinyodin_obi_pkg::*;
#(
    parameter int  SPK_AW  = SPK_AW_DEF,
    parameter int  NEUR_AW = NEUR_AW_DEF,
    parameter int  SYN_AW  = SYN_AW_DEF,
    parameter type req_t   = obi_req_t,
    parameter type rsp_t   = obi_resp_t
) (
    input  logic              CLK,
    input  logic              RST,
    input  req_t              obi_req_i,
    output rsp_t              obi_rsp_o,
    input  logic              core_busy_i,
    output logic [2:0]        mem_en_o,
    output logic              mem_we_o,
    output logic [SYN_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       spk_rdata_i,
    input  logic [31:0]       neur_rdata_i,
    input  logic [31:0]       syn_rdata_i,
    output logic [31:0]       ctrl_o,
    output logic              ctrl_wr_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    state_e            state_q, state_d;
    tgt_e              dec_tgt, tgt_q;
    logic [SYN_AW-1:0] dec_addr;
    logic              dec_stall;
    logic              we_q;
    logic [31:0]       ctrl_q;
    logic              ctrl_wr_q;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    // Byte enables are not used: every write is a full word.
    logic unused_be;
    assign unused_be = ^obi_req_i.be;

    tinyodin_obi_decode #(
        .SPK_AW  (SPK_AW),
        .NEUR_AW (NEUR_AW),
        .SYN_AW  (SYN_AW)
    ) u_decode (
        .addr      (obi_req_i.addr),
        .core_busy (core_busy_i),
        .tgt       (dec_tgt),
        .word_addr (dec_addr),
        .stall     (dec_stall)
    );

    // Reset also blocks grants so no strobe leaks out during a reset cycle.
    assign gnt = obi_req_i.req & ~dec_stall & ~RST;

    // Response FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: stay in RESP while requests keep being accepted back-to-back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (gnt)  state_d = ST_RESP;
            ST_RESP: if (!gnt) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture target/direction of the accepted request and update the control register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tgt_q     <= TGT_SPK;
            we_q      <= 1'b0;
            ctrl_q    <= '0;
            ctrl_wr_q <= 1'b0;
        end else begin
            ctrl_wr_q <= gnt & obi_req_i.we & (dec_tgt == TGT_CTRL);
            if (gnt) begin
                tgt_q <= dec_tgt;
                we_q  <= obi_req_i.we;
                if (obi_req_i.we && dec_tgt == TGT_CTRL) ctrl_q <= obi_req_i.wdata;
            end
        end
    end

    // SRAM strobes are driven in the accept cycle only, for memory regions.
    always_comb begin
        mem_en_o    = '0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (gnt && dec_tgt != TGT_CTRL) begin
            mem_en_o    = tgt_onehot(dec_tgt);
            mem_we_o    = obi_req_i.we;
            mem_addr_o  = dec_addr;
            mem_wdata_o = obi_req_i.wdata;
        end
    end

    // Read data mux steered by the registered target; writes return zero.
    always_comb begin
        rvalid = (state_q == ST_RESP) & ~RST;
        rdata  = '0;
        if (rvalid && !we_q) begin
            case (tgt_q)
                TGT_SPK:  rdata = spk_rdata_i;
                TGT_NEUR: rdata = neur_rdata_i;
                TGT_SYN:  rdata = syn_rdata_i;
                default:  rdata = ctrl_q;
            endcase
        end
    end

    // Pack the response struct.
    always_comb begin
        obi_rsp_o        = '0;
        obi_rsp_o.gnt    = gnt;
        obi_rsp_o.rvalid = rvalid;
        obi_rsp_o.rdata  = rdata;
    end

    assign ctrl_o    = ctrl_q;
    assign ctrl_wr_o = ctrl_wr_q & ~RST;

endmodule

// File: tb/tb_tinyodin_obi_responder.sv
// Scoreboard bench for tinyodin_obi_responder: directed scenarios followed by
// randomized traffic, checked against a region-level memory model.
module tb_tinyodin_obi_responder;
    import tinyodin_obi_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    obi_req_t    req;
    obi_resp_t   rsp;
    logic        core_busy;
    logic [2:0]  mem_en;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] spk_rd  = '0;
    logic [31:0] neur_rd = '0;
    logic [31:0] syn_rd  = '0;
    logic [31:0] ctrl;
    logic        ctrl_wr;

    always #5 CLK = ~CLK;

    tinyodin_obi_responder dut (
        .CLK          (CLK),
        .RST          (RST),
        .obi_req_i    (req),
        .obi_rsp_o    (rsp),
        .core_busy_i  (core_busy),
        .mem_en_o     (mem_en),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .spk_rdata_i  (spk_rd),
        .neur_rdata_i (neur_rd),
        .syn_rdata_i  (syn_rd),
        .ctrl_o       (ctrl),
        .ctrl_wr_o    (ctrl_wr)
    );

    // SRAMs with 1-cycle read latency, driven only by the DUT strobes.
    bit [31:0] spk_sram  [64];
    bit [31:0] neur_sram [256];
    bit [31:0] syn_sram  [8192];

    always @(posedge CLK) begin
        if (mem_en[0]) begin
            if (mem_we) spk_sram[mem_addr[5:0]] <= mem_wdata;
            else        spk_rd <= spk_sram[mem_addr[5:0]];
        end
        if (mem_en[1]) begin
            if (mem_we) neur_sram[mem_addr[7:0]] <= mem_wdata;
            else        neur_rd <= neur_sram[mem_addr[7:0]];
        end
        if (mem_en[2]) begin
            if (mem_we) syn_sram[mem_addr] <= mem_wdata;
            else        syn_rd <= syn_sram[mem_addr];
        end
    end

    // Reference model: what each region holds from the host's point of view.
    bit [31:0] ref_spk  [64];
    bit [31:0] ref_neur [256];
    bit [31:0] ref_syn  [8192];
    bit [31:0] ref_ctrl = '0;

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] ctrl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int   checks   = 0;
    int   failures = 0;
    logic model_acc     = 1'b0;
    logic model_ctrl_wr = 1'b0;
    logic prev_acc      = 1'b0;
    logic prev_cw       = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One host transfer: hold the request until the model says it is granted.
    task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input int busy_mode);
        int          region;
        int          aw;
        logic [31:0] off;
        logic        exp_gnt;
        logic [2:0]  exp_en;
        exp_t        e;
        region    = int'(addr[21:20]);
        aw        = (region == 0) ? 6 : (region == 1) ? 8 : 13;
        off       = addr % (32'd1 << aw);
        req.req   = 1'b1;
        req.we    = we;
        req.addr  = addr;
        req.wdata = wdata;
        req.be    = 4'($urandom);
        for (int cyc = 0; cyc < 64; cyc++) begin
            case (busy_mode)
                1:       core_busy = (cyc < 6) ? 1'($urandom_range(0, 1)) : 1'b0;
                2:       core_busy = (cyc < 3);
                3:       core_busy = 1'b1;
                default: core_busy = 1'b0;
            endcase
            exp_gnt       = !(core_busy && (region == 1 || region == 2));
            model_acc     = exp_gnt;
            model_ctrl_wr = exp_gnt && we && region == 3;
            if (exp_gnt) begin
                e.rdata = '0;
                if (we) begin
                    case (region)
                        0:       ref_spk[off]  = wdata;
                        1:       ref_neur[off] = wdata;
                        2:       ref_syn[off]  = wdata;
                        default: ref_ctrl      = wdata;
                    endcase
                end else begin
                    case (region)
                        0:       e.rdata = ref_spk[off];
                        1:       e.rdata = ref_neur[off];
                        2:       e.rdata = ref_syn[off];
                        default: e.rdata = ref_ctrl;
                    endcase
                end
                e.ctrl = ref_ctrl;
                sb.push_back(e);
            end
            @(negedge CLK);
            check("gnt", {31'd0, rsp.gnt}, {31'd0, exp_gnt});
            exp_en = (exp_gnt && region != 3) ? 3'(1 << region) : 3'b000;
            check("mem_en", {29'd0, mem_en}, {29'd0, exp_en});
            if (exp_gnt && region != 3) begin
                check("mem_addr", {19'd0, mem_addr}, off);
                check("mem_we", {31'd0, mem_we}, {31'd0, we});
                if (we) check("mem_wdata", mem_wdata, wdata);
            end
            @(posedge CLK);
            #1;
            if (exp_gnt) return;
        end
        checks++;
        failures++;
        $display("FAIL grant_timeout addr=0x%08h never granted within 64 cycles", addr);
        req.req   = 1'b0;
        model_acc = 1'b0;
        model_ctrl_wr = 1'b0;
    endtask

    task automatic idle_cycle();
        req.req       = 1'b0;
        core_busy     = 1'($urandom_range(0, 1));
        model_acc     = 1'b0;
        model_ctrl_wr = 1'b0;
        @(negedge CLK);
        check("idle_gnt", {31'd0, rsp.gnt}, 32'd0);
        check("idle_mem_en", {29'd0, mem_en}, 32'd0);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: rvalid/ctrl_wr timing every cycle, payload popped from the scoreboard.
    always @(negedge CLK) begin
        check("rvalid", {31'd0, rsp.rvalid}, {31'd0, prev_acc && !RST});
        check("ctrl_wr", {31'd0, ctrl_wr}, {31'd0, prev_cw && !RST});
        if (rsp.rvalid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rvalid rdata=0x%08h with empty scoreboard", rsp.rdata);
            end else begin
                mon_e = sb.pop_front();
                check("rdata", rsp.rdata, mon_e.rdata);
                check("ctrl_o", ctrl, mon_e.ctrl);
            end
        end
        prev_acc = model_acc && !RST;
        prev_cw  = model_ctrl_wr && !RST;
    end

    initial begin
        logic [31:0] a;
        req       = '0;
        core_busy = 1'b0;

        // Reset with a live neuron request: nothing may be granted or strobed.
        req.req  = 1'b1;
        req.we   = 1'b1;
        req.addr = 32'h0010_0003;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("rst_gnt", {31'd0, rsp.gnt}, 32'd0);
            check("rst_mem_en", {29'd0, mem_en}, 32'd0);
            check("rst_rdata", rsp.rdata, 32'd0);
            check("rst_ctrl", ctrl, 32'd0);
        end
        @(posedge CLK);
        #1;
        RST     = 1'b0;
        req.req = 1'b0;
        idle_cycle();

        // Neuron write, then spike write/read.
        do_txn(32'h0010_0005, 1'b1, 32'h0015_E000, 0);
        idle_cycle();
        do_txn(32'h0000_0019, 1'b1, 32'hA5A5_0001, 0);
        do_txn(32'h0000_0019, 1'b0, 32'h0, 0);
        do_txn(32'h0010_0005, 1'b0, 32'h0, 0);
        idle_cycle();

        // Synapse burst with no bubbles, then read back part of it.
        for (int i = 0; i < 13; i++)
            do_txn(32'h0020_0C80 + 32'(i), 1'b1, 32'hC0DE_0000 + 32'(i), 0);
        do_txn(32'h0020_0C80, 1'b0, 32'h0, 0);
        do_txn(32'h0020_0C8C, 1'b0, 32'h0, 0);
        idle_cycle();

        // Control write and readback.
        do_txn(32'h0030_0000, 1'b1, 32'hFF00_0400, 0);
        do_txn(32'h0030_0000, 1'b0, 32'h0, 0);
        idle_cycle();

        // Busy core: spike still served, synapse waits for busy to drop.
        do_txn(32'h0000_0002, 1'b1, 32'h1234_5678, 3);
        do_txn(32'h0020_0C85, 1'b0, 32'h0, 2);
        idle_cycle();

        // Reset in the response cycle of a granted read.
        do_txn(32'h0000_0019, 1'b0, 32'h0, 0);
        RST           = 1'b1;
        req.req       = 1'b0;
        model_acc     = 1'b0;
        model_ctrl_wr = 1'b0;
        @(posedge CLK);
        #1;
        check("post_rst_ctrl", ctrl, 32'd0);
        check("post_rst_ctrl_wr", {31'd0, ctrl_wr}, 32'd0);
        sb.delete();
        ref_ctrl = '0;
        RST      = 1'b0;
        do_txn(32'h0000_0019, 1'b0, 32'h0, 0);
        do_txn(32'h0030_0000, 1'b0, 32'h0, 0);
        idle_cycle();

        // Randomized traffic with aliasing upper bits and random busy.
        for (int n = 0; n < 300; n++) begin
            a = ($urandom & 32'hFFCF_E00F) | (32'($urandom_range(0, 3)) << 20);
            do_txn(a, 1'($urandom_range(0, 1)), $urandom, 1);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        idle_cycle();
        idle_cycle();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
